// File: rtl/div.sv
// Sequential signed restoring divider: one quotient bit per clock on operand
// magnitudes, signs restored in a final fix-up cycle. Result is {remainder, quotient}.
module div #(
  parameter int WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic [2*WIDTH-1:0]      p
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] u;
    u = x;
    return x[WIDTH-1] ? ((~u) + WIDTH'(1)) : u;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // quo_q starts holding |dividend|; its MSB feeds the remainder each step
  assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            p_d    = {dividend, {WIDTH{1'b1}}};
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            quo_d   = magnitude(dividend);
            dvs_d   = magnitude(divisor);
            qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
            rem_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        p_d     = {cond_neg(rem_q[WIDTH-1:0], rneg_q), cond_neg(quo_q, qneg_q)};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      p_q     <= p_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign p           = p_q;

endmodule

// File: tb/tb_div.sv
// Directed and random bench for the sequential signed divider, checked against
// plain integer division/modulo on 64-bit values.
module tb_div;

  logic               clock;
  logic               clear;
  logic               start;
  logic signed [31:0] dividend;
  logic signed [31:0] divisor;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic [63:0]        p;

  int errors = 0;
  int checks = 0;

  div #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .p           (p)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic signed [31:0] a, input logic signed [31:0] b);
    longint q, r;
    q = longint'(a) / longint'(b);
    r = longint'(a) % longint'(b);
    return {r[31:0], q[31:0]};
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // Accepting edge, then wait for done; checks latency, busy profile and result.
  task automatic finish_op(input string tag, input logic [63:0] exp, input bit repulse);
    int lat;
    int busy_bad;
    lat = 0;
    busy_bad = 0;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    if (busy !== 1'b1) busy_bad++;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (repulse && n == 10) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom | 32'd1;
      end
      if (repulse && n == 11) start = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_p"}, p, exp);
    chk({tag, "_dbz"}, {63'd0, div_by_zero}, 64'd0);
    chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    chk({tag, "_busy_prof"}, 64'(busy_bad), 64'd0);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clock);
    #1;
    chk({tag, "_done_drop"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic signed [31:0] ra, rb;
    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("rst_p", p, 64'd0);
    @(negedge clock);
    clear = 1'b0;

    launch(32'd100, 32'd7);
    finish_op("pos", 64'h00000002_0000000E, 1'b0);
    idle_check("pos");

    launch(-32'sd100, 32'd7);
    finish_op("negdvd", 64'hFFFFFFFE_FFFFFFF2, 1'b0);
    launch(32'd100, -32'sd7);
    finish_op("negdvs", 64'h00000002_FFFFFFF2, 1'b0);
    launch(-32'sd100, -32'sd7);
    finish_op("negboth", 64'hFFFFFFFE_0000000E, 1'b0);
    launch(32'h80000000, 32'hFFFFFFFF);
    finish_op("ovf", 64'h00000000_80000000, 1'b0);
    launch(32'd5, 32'd9);
    finish_op("zeroq", 64'h00000005_00000000, 1'b0);
    idle_check("zeroq");

    // Divide by zero completes at the accepting edge without going busy.
    @(negedge clock);
    launch(32'd5, 32'd0);
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("dbz_done", {63'd0, done}, 64'd1);
    chk("dbz_flag", {63'd0, div_by_zero}, 64'd1);
    chk("dbz_busy", {63'd0, busy}, 64'd0);
    chk("dbz_p", p, 64'h00000005_FFFFFFFF);
    @(posedge clock);
    #1;
    chk("dbz_done_drop", {63'd0, done}, 64'd0);
    chk("dbz_hold", {63'd0, div_by_zero}, 64'd1);
    chk("dbz_busy2", {63'd0, busy}, 64'd0);
    launch(32'd6, 32'd3);
    finish_op("after_dbz", 64'h00000000_00000002, 1'b0);

    // Start while busy is ignored.
    launch(32'd1000, 32'd10);
    finish_op("repulse", 64'h00000000_00000064, 1'b1);

    // Start issued during the done cycle begins the next op straight away.
    launch(32'd77, 32'd5);
    finish_op("b2b", 64'h00000002_0000000F, 1'b0);

    // Asynchronous clear mid-operation.
    launch(32'd1000, 32'd10);
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    chk("clr_busy", {63'd0, busy}, 64'd0);
    chk("clr_done", {63'd0, done}, 64'd0);
    chk("clr_p", p, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("clr_hold_done", {63'd0, done}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    launch(32'd9, 32'd2);
    finish_op("post_clr", 64'h00000001_00000004, 1'b0);
    idle_check("post_clr");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'sd1 * 32'($urandom_range(1, 1000));
        default: rb = (i % 8 == 3) ? 32'sh80000000 : 32'($urandom_range(1, 65535));
      endcase
      if (i == 5) ra = 32'sh80000000;
      if (rb == 0) rb = 32'sd3;
      @(negedge clock);
      launch(ra, rb);
      finish_op($sformatf("rnd%0d", i), model(ra, rb), 1'b0);
    end
    idle_check("rnd_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Sequential signed 32-bit divider. It is the inverse-operation companion to the combinational Booth multiplier in the ALU.
- Takes dividend and divisor on a start pulse and runs one restoring-division step per clock, on operand magnitudes.
- Returns quotient and remainder packed as {remainder, quotient} on a 64-bit result, matching the multiplier's 64-bit product for the HI/LO registers.
- Handshake is start/busy/done so the control unit can stall during DIV.

Parameters:
- WIDTH, 32, operand width. The result is 2*WIDTH. Iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- dividend  in  WIDTH  signed dividend. Sampled on the accepting edge only.
- divisor  in  WIDTH  signed divisor. Sampled on the accepting edge only.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result valid.
- div_by_zero  out  1  set with done when divisor==0. Held until next accepted start.
- p  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}. Held until next accepted start.

Behaviour:
- Reset: clear=1 asynchronously forces state=IDLE and busy=0, done=0, div_by_zero=0, p=0. Also clears internal count, accumulator and sign flags. An operation in flight is abandoned with no done.
- States: IDLE, CALC, FIX.
- IDLE, start=1, divisor!=0, at edge E0:
  - latch |dividend| and |divisor| as unsigned WIDTH-bit magnitudes (two's complement negate; -2^31 maps to 0x80000000 unsigned);
  - latch q_neg = dividend sign XOR divisor sign, and r_neg = dividend sign;
  - clear partial remainder (WIDTH+1 bits) and count;
  - busy=1, div_by_zero=0; next state CALC.
- IDLE, start=1, divisor==0, at E0:
  - p = {dividend, all-ones}, div_by_zero=1, done=1 at E0;
  - busy stays 0; state stays IDLE.
- CALC, edges E1..E(WIDTH), one step per edge:
  - shift {rem, quo} left 1 and bring in the next dividend MSB;
  - trial = rem - |divisor|;
  - if trial >= 0 then rem=trial and the quotient LSB = 1, else the LSB = 0;
  - count increments. At count==WIDTH-1 the next state is FIX.
- FIX, edge E(WIDTH+1):
  - quotient negated if q_neg; remainder negated if r_neg;
  - p updated, done=1, busy=0; next state IDLE.
- Latency: done asserted after edge WIDTH+1 (33) counting from the accepting edge E0. It is constant regardless of operand values.
- done: high for exactly one cycle, then cleared on the next edge.
- start while busy: ignored, with no effect on the operation or the operands.
- Back-to-back: start high during the done cycle (state is IDLE) is accepted at the following edge.
- Arithmetic:
  - truncation toward zero; remainder sign follows the dividend;
  - the invariant dividend == quotient*divisor + remainder holds for all non-zero divisors;
  - overflow case -2^31 / -1 yields quotient 0x80000000, remainder 0, no flag.
- Operand inputs may change freely after E0; the result depends only on the latched values.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Positive operands: 100 / 7 -> after 33 cycles done=1 for 1 cycle, p=0x00000002_0000000E, div_by_zero=0; busy high for cycles 1..32.
- Sign cases:
  - -100 / 7 -> p=0xFFFFFFFE_FFFFFFF2;
  - 100 / -7 -> p=0x00000002_FFFFFFF2;
  - -100 / -7 -> p=0xFFFFFFFE_0000000E.
- Overflow and zero quotient:
  - 0x80000000 / 0xFFFFFFFF -> p=0x00000000_80000000;
  - 5 / 9 -> p=0x00000005_00000000.
- Divide by zero: 5 / 0 -> done and div_by_zero high at the edge after start, p=0x00000005_FFFFFFFF, busy never asserted. A following 6/3 clears div_by_zero and gives p=0x00000000_00000002.
- Handshake:
  - start re-pulsed with different operands at cycle 10 of 1000/10 -> ignored, p=0x00000000_00000064;
  - start held during the done cycle -> second operation begins the next edge.
- Reset mid-operation: assert clear at cycle 15 of 1000/10 -> busy, done and p go to 0 immediately (asynchronously) with no done pulse. After release, 9/2 -> p=0x00000001_00000004.
